// File: rtl/instr_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the boot-time program loader.
// The loader takes the slave view; whatever feeds the stream and watches status takes the master view.
interface instr_loader_if #(
  parameter int INSTR_W = 19,
  parameter int ADDR_W  = 12
);
  logic               start;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_hold;
  logic               busy;
  logic               done;
  logic               error;
  logic [1:0]         err_code;
  logic [ADDR_W:0]    word_count;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata,
    output cpu_hold, busy, done, error, err_code, word_count
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_hold, busy, done, error, err_code, word_count
  );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: reads a length-prefixed stream of 3-byte words, writes them into instruction memory
// from address 0, verifies a trailing XOR checksum, and keeps the CPU in reset until a load succeeds.
module instr_loader #(
  parameter int INSTR_W = 19,
  parameter int ADDR_W  = 12
) (
  input  logic         clk,
  input  logic         reset,
  instr_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_WORD   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_FMT  = 2'd2;
  localparam logic [1:0] ERR_CHK  = 2'd3;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_e             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         b0_q, b0_d, b1_q, b1_d, chk_q, chk_d;
  logic               done_q, done_d, error_q, error_d, cpu_hold_q, cpu_hold_d, we_q, we_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [ADDR_W:0]    wc_q, wc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;

  logic        accept_s;
  logic [23:0] word24_s;
  logic [31:0] n_s;
  logic        last_word_s;

  assign bus.in_ready = state_q inside {S_LEN_LO, S_LEN_HI, S_WORD, S_CHECK};
  assign bus.busy     = state_q inside {S_LEN_LO, S_LEN_HI, S_WORD, S_CHECK};
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign word24_s     = {bus.in_data, b1_q, b0_q};
  assign n_s          = {16'd0, bus.in_data, len_q[7:0]};
  // The word accepted now is the Nth when the count before it is N-1.
  assign last_word_s  = ({{(31-ADDR_W){1'b0}}, wc_q} + 32'd1) == {16'd0, len_q};

  // Next-state and output-register computation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    chk_d      = chk_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    wc_d       = wc_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_hold_d = cpu_hold_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          state_d    = S_LEN_LO;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          wc_d       = '0;
          chk_d      = 8'd0;
          cpu_hold_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_LO: begin
        if (accept_s) begin
          len_d[7:0] = bus.in_data;
          chk_d      = chk_update(chk_q, bus.in_data);
          state_d    = S_LEN_HI;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          len_d[15:8] = bus.in_data;
          chk_d       = chk_update(chk_q, bus.in_data);
          if (n_s > (32'd1 << ADDR_W)) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_LEN;
          end else if (n_s == 32'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_WORD;
            idx_d   = 2'd0;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_WORD: begin
        if (accept_s) begin
          chk_d = chk_update(chk_q, bus.in_data);
          case (idx_q)
            2'd0: begin
              b0_d  = bus.in_data;
              idx_d = 2'd1;
            end
            2'd1: begin
              b1_d  = bus.in_data;
              idx_d = 2'd2;
            end
            2'd2: begin
              // Bits above INSTR_W must be zero; a malformed word is never written.
              if ((word24_s >> INSTR_W) != 24'd0) begin
                state_d    = S_ERROR;
                error_d    = 1'b1;
                err_code_d = ERR_FMT;
              end else begin
                we_d    = 1'b1;
                addr_d  = wc_q[ADDR_W-1:0];
                wdata_d = word24_s[INSTR_W-1:0];
                wc_d    = wc_q + {{ADDR_W{1'b0}}, 1'b1};
                idx_d   = 2'd0;
                state_d = last_word_s ? S_CHECK : S_WORD;
              end
            end
            default: idx_d = 2'd0;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      S_CHECK: begin
        if (accept_s) begin
          if (bus.in_data == chk_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            err_code_d = ERR_CHK;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      idx_q      <= 2'd0;
      b0_q       <= 8'd0;
      b1_q       <= 8'd0;
      chk_q      <= 8'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      wc_q       <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      chk_q      <= chk_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      wc_q       <= wc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.err_code   = err_code_q;
  assign bus.word_count = wc_q;

endmodule
